// File: rtl/mithril_mod_pkg.sv
// Shared constants and state encoding for the Mithril limb-serial modular add/sub unit.
package mithril_mod_pkg;

  // 2^255 - 19: bits 254..5 set, low five bits 01101.
  localparam logic [255:0] CURVE25519_P = {1'b0, {250{1'b1}}, 5'b01101};

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    COMPUTE,
    SELECT,
    WIPE,
    DONE
  } state_t;

endpackage

// File: rtl/mithril_limb_addsub.sv
// One LIMB_W-bit add/sub slice; cin/cout carry the carry (add) or the borrow (sub).
module mithril_limb_addsub #(
  parameter int unsigned LIMB_W = 64
) (
  input  logic [LIMB_W-1:0] x,
  input  logic [LIMB_W-1:0] y,
  input  logic              cin,
  input  logic              sub,
  output logic [LIMB_W-1:0] sum,
  output logic              cout
);

  logic [LIMB_W:0] full;

  // In subtract mode the top bit of the widened difference is the borrow-out.
  always_comb begin
    full = '0;
    if (sub)
      full = {1'b0, x} - {1'b0, y} - {{LIMB_W{1'b0}}, cin};
    else
      full = {1'b0, x} + {1'b0, y} + {{LIMB_W{1'b0}}, cin};
  end

  assign sum  = full[LIMB_W-1:0];
  assign cout = full[LIMB_W];

endmodule

// File: rtl/mithril_addsub_mod_serial.sv
// Limb-serial (a +/- b) mod m with operand range check and fixed, data-independent latency.
module mithril_addsub_mod_serial
  import mithril_mod_pkg::*;
#(
  parameter int unsigned WIDTH  = 256,
  parameter int unsigned LIMB_W = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic [WIDTH-1:0] modulus,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             busy,
  output logic             error
);

  localparam int unsigned NLIMBS = WIDTH / LIMB_W;
  localparam int unsigned CNT_W  = (NLIMBS > 1) ? $clog2(NLIMBS) : 1;

  if ((LIMB_W == 0) || ((WIDTH % LIMB_W) != 0)) begin : g_bad_width
    $error("mithril_addsub_mod_serial: WIDTH must be a non-zero multiple of LIMB_W");
  end

  state_t             state;
  logic [WIDTH-1:0]   a_sh, b_sh, m_sh, s_acc, t_acc;
  logic               op_q;
  logic               c1_q, c2_q, r1_q, r2_q;
  logic [CNT_W-1:0]   cnt;

  logic [LIMB_W-1:0]  s_limb, t_limb, ra_limb, rb_limb;
  logic               c1_n, c2_n, r1_n, r2_n;
  logic               is_sub;
  logic               sel_t, err_n;
  logic [WIDTH-1:0]   m_sel, sel_res;

  assign is_sub = (op_q == OP_SUB);
  assign m_sel  = (modulus == '0) ? WIDTH'(CURVE25519_P) : modulus;

  mithril_limb_addsub #(.LIMB_W(LIMB_W)) u_c1 (
    .x(a_sh[LIMB_W-1:0]), .y(b_sh[LIMB_W-1:0]), .cin(c1_q), .sub(is_sub),
    .sum(s_limb), .cout(c1_n)
  );

  mithril_limb_addsub #(.LIMB_W(LIMB_W)) u_c2 (
    .x(s_limb), .y(m_sh[LIMB_W-1:0]), .cin(c2_q), .sub(~is_sub),
    .sum(t_limb), .cout(c2_n)
  );

  mithril_limb_addsub #(.LIMB_W(LIMB_W)) u_r1 (
    .x(a_sh[LIMB_W-1:0]), .y(m_sh[LIMB_W-1:0]), .cin(r1_q), .sub(1'b1),
    .sum(ra_limb), .cout(r1_n)
  );

  mithril_limb_addsub #(.LIMB_W(LIMB_W)) u_r2 (
    .x(b_sh[LIMB_W-1:0]), .y(m_sh[LIMB_W-1:0]), .cin(r2_q), .sub(1'b1),
    .sum(rb_limb), .cout(r2_n)
  );

  // Mask select: both candidates are always formed, one is kept by an AND mask.
  always_comb begin
    sel_t   = is_sub ? c1_q : (c1_q | ~c2_q);
    err_n   = ~(r1_q & r2_q);
    sel_res = ((t_acc & {WIDTH{sel_t}}) | (s_acc & {WIDTH{~sel_t}})) & {WIDTH{~err_n}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      result <= '0;
      done   <= 1'b0;
      busy   <= 1'b0;
      error  <= 1'b0;
      a_sh   <= '0;
      b_sh   <= '0;
      m_sh   <= '0;
      s_acc  <= '0;
      t_acc  <= '0;
      op_q   <= 1'b0;
      c1_q   <= 1'b0;
      c2_q   <= 1'b0;
      r1_q   <= 1'b0;
      r2_q   <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= operand_a;
            b_sh  <= operand_b;
            m_sh  <= m_sel;
            op_q  <= op_sub;
            cnt   <= '0;
            c1_q  <= 1'b0;
            c2_q  <= 1'b0;
            r1_q  <= 1'b0;
            r2_q  <= 1'b0;
            busy  <= 1'b1;
            state <= COMPUTE;
          end
        end
        COMPUTE: begin
          // Operand registers refill from the top with the range-check differences;
          // those bits are never read back and are cleared in WIPE.
          a_sh  <= (a_sh >> LIMB_W) | (WIDTH'(ra_limb) << (WIDTH - LIMB_W));
          b_sh  <= (b_sh >> LIMB_W) | (WIDTH'(rb_limb) << (WIDTH - LIMB_W));
          m_sh  <= (m_sh >> LIMB_W) | (m_sh << (WIDTH - LIMB_W));
          s_acc <= (s_acc >> LIMB_W) | (WIDTH'(s_limb) << (WIDTH - LIMB_W));
          t_acc <= (t_acc >> LIMB_W) | (WIDTH'(t_limb) << (WIDTH - LIMB_W));
          c1_q  <= c1_n;
          c2_q  <= c2_n;
          r1_q  <= r1_n;
          r2_q  <= r2_n;
          cnt   <= cnt + 1'b1;
          if (cnt == CNT_W'(NLIMBS - 1))
            state <= SELECT;
        end
        SELECT: begin
          result <= sel_res;
          error  <= err_n;
          state  <= WIPE;
        end
        WIPE: begin
          a_sh  <= '0;
          b_sh  <= '0;
          m_sh  <= '0;
          s_acc <= '0;
          t_acc <= '0;
          op_q  <= 1'b0;
          c1_q  <= 1'b0;
          c2_q  <= 1'b0;
          r1_q  <= 1'b0;
          r2_q  <= 1'b0;
          cnt   <= '0;
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          if (!start) begin
            done  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          result <= '0;
          error  <= 1'b1;
          busy   <= 1'b0;
          done   <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mithril_addsub_mod_serial.sv
// Directed bench for mithril_addsub_mod_serial using immediate assertions at each check.
module tb_mithril_addsub_mod_serial;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         op_sub;
  logic [255:0] operand_a, operand_b, modulus;
  logic [255:0] result;
  logic         done, busy, error;

  int n_tests = 0;
  int n_fail  = 0;

  logic [255:0] P, M2;

  mithril_addsub_mod_serial #(.WIDTH(256), .LIMB_W(64)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_sub(op_sub),
    .operand_a(operand_a), .operand_b(operand_b), .modulus(modulus),
    .result(result), .done(done), .busy(busy), .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Start at E0, then follow edges E1..E6; operands are scrambled after E0 to prove capture.
  task automatic run_op(input logic [255:0] a, input logic [255:0] b, input logic [255:0] m,
                        input logic sub, input logic [255:0] exp_r, input logic exp_e,
                        input string name, input bit hold, input bit pulse);
    @(negedge clk);
    operand_a = a;
    operand_b = b;
    modulus   = m;
    op_sub    = sub;
    start     = 1'b1;
    @(posedge clk);
    for (int e = 1; e <= 6; e++) begin
      @(negedge clk);
      if (e == 1) begin
        operand_a = '1;
        operand_b = '1;
        modulus   = 256'd5;
        op_sub    = ~sub;
      end
      start = hold ? 1'b1 : ((pulse && (e == 2)) ? 1'b1 : 1'b0);
      @(posedge clk);
      #1;
      check($sformatf("%s busy@E%0d", name, e), {255'd0, busy}, {255'd0, (e < 6)});
      check($sformatf("%s done@E%0d", name, e), {255'd0, done}, {255'd0, (e == 6)});
      if (e >= 5) begin
        check($sformatf("%s result@E%0d", name, e), result, exp_r);
        check($sformatf("%s error@E%0d", name, e), {255'd0, error}, {255'd0, exp_e});
      end
    end
    if (hold) begin
      for (int k = 0; k < 3; k++) begin
        @(posedge clk);
        #1;
        check($sformatf("%s hold_done%0d", name, k), {255'd0, done}, 256'd1);
        check($sformatf("%s hold_busy%0d", name, k), {255'd0, busy}, 256'd0);
        check($sformatf("%s hold_result%0d", name, k), result, exp_r);
      end
    end
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    check($sformatf("%s drop_done", name), {255'd0, done}, 256'd0);
    check($sformatf("%s drop_busy", name), {255'd0, busy}, 256'd0);
    check($sformatf("%s drop_result", name), result, exp_r);
  endtask

  initial begin
    P  = (256'd1 << 255) - 256'd19;
    M2 = 256'd0 - 256'd189;

    rst_n     = 1'b0;
    start     = 1'b0;
    op_sub    = 1'b0;
    operand_a = '0;
    operand_b = '0;
    modulus   = '0;
    #2;
    check("reset result", result, 256'd0);
    check("reset done", {255'd0, done}, 256'd0);
    check("reset busy", {255'd0, busy}, 256'd0);
    check("reset error", {255'd0, error}, 256'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(256'd5, 256'd7, 256'd0, 1'b0, 256'd12, 1'b0, "add5_7", 1'b1, 1'b0);
    run_op(M2 - 256'd1, M2 - 256'd1, M2, 1'b0, M2 - 256'd2, 1'b0, "add_m2max", 1'b0, 1'b0);
    run_op(P - 256'd1, P - 256'd1, 256'd0, 1'b0, P - 256'd2, 1'b0, "add_pmax", 1'b0, 1'b1);
    run_op(256'd3, 256'd5, 256'd0, 1'b1, P - 256'd2, 1'b0, "sub3_5", 1'b0, 1'b0);
    run_op(256'd9, 256'd9, 256'd0, 1'b1, 256'd0, 1'b0, "sub9_9", 1'b0, 1'b0);
    run_op(P, 256'd1, 256'd0, 1'b0, 256'd0, 1'b1, "range_a", 1'b0, 1'b0);
    run_op(256'd6, 256'd7, 256'd11, 1'b0, 256'd2, 1'b0, "add_mod11", 1'b0, 1'b0);
    run_op(256'd0, 256'd10, 256'd11, 1'b1, 256'd1, 1'b0, "sub_mod11", 1'b0, 1'b0);
    run_op(256'd5, 256'd11, 256'd11, 1'b0, 256'd0, 1'b1, "range_b", 1'b0, 1'b0);
    run_op(256'd10, 256'd10, 256'd11, 1'b0, 256'd9, 1'b0, "add10_10", 1'b0, 1'b0);

    // Abort during COMPUTE: previous result (9) must vanish with the reset.
    @(negedge clk);
    operand_a = 256'd1;
    operand_b = 256'd2;
    modulus   = 256'd0;
    op_sub    = 1'b0;
    start     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("midop busy", {255'd0, busy}, 256'd1);
    rst_n = 1'b0;
    #1;
    check("abort result", result, 256'd0);
    check("abort done", {255'd0, done}, 256'd0);
    check("abort busy", {255'd0, busy}, 256'd0);
    check("abort error", {255'd0, error}, 256'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(256'd1, 256'd1, 256'd0, 1'b0, 256'd2, 1'b0, "after_rst", 1'b1, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("idle busy", {255'd0, busy}, 256'd0);
    check("idle done", {255'd0, done}, 256'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
